// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS memory subsystem.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W        = 32;
  localparam int DEF_MEM_DEPTH = 1024;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // One outstanding response slot: who gets it and whether it is an error.
  typedef struct packed {
    logic  vld;
    port_e port;
    logic  err;
  } pend_t;

endpackage

// File: rtl/mips_sram_1p.sv
// Single-port synchronous RAM, one read or write per cycle.
// Latency: read data valid one cycle after en_i with we_i=0.
// Backpressure: none; accepts an access every cycle.
module mips_sram_1p
  import mips_pkg::*;
#(
  parameter int  DEPTH = DEF_MEM_DEPTH,
  parameter int  WIDTH = WORD_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write on we_i, otherwise register the addressed word for next cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory; data wins unless fetch is starved.
// Latency: grant combinational in the request cycle; read/error response exactly one cycle later.
// Backpressure: requester holds its request until gnt; halt blocks all new grants.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int  MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int  STARVE_LIMIT = 4,
  localparam int AW           = $clog2(MEM_DEPTH),
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_err,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  pend_t             pend_q, pend_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_oor, d_oor, force_i;

  // Any address bit above the index makes the access out of range.
  assign i_oor   = (i_addr >> AW) != 32'd0;
  assign d_oor   = (d_addr >> AW) != 32'd0;
  assign force_i = i_req && (starve_cnt_q == SLIM);

  // Grant selection: data first, fetch when starved; nothing during reset or halt.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst && !halt) begin
      if (d_req && !force_i) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Memory strobes and response bookkeeping for the granted access.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_d      = '0;
    if (d_gnt) begin
      pend_d.vld  = d_oor || !d_we;
      pend_d.port = PORT_D;
      pend_d.err  = d_oor;
      if (!d_oor) begin
        mem_en      = 1'b1;
        mem_we      = d_we;
        mem_addr_d  = d_addr[AW-1:0];
        mem_wdata_d = d_wdata;
      end
    end else if (i_gnt) begin
      pend_d.vld  = 1'b1;
      pend_d.port = PORT_I;
      pend_d.err  = i_oor;
      if (!i_oor) begin
        mem_en     = 1'b1;
        mem_addr_d = i_addr[AW-1:0];
      end
    end
  end

  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;

  // Starvation counter: counts fetch denials, frozen while halted.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!halt) begin
      if (i_gnt || !i_req) begin
        starve_cnt_d = '0;
      end else if (d_gnt && starve_cnt_q != SLIM) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  // State registers; reset drops any outstanding response.
  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_cnt_q <= '0;
      pend_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pend_q       <= pend_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Response routing; error responses carry zero data.
  assign i_rvalid = !rst && pend_q.vld && (pend_q.port == PORT_I);
  assign d_rvalid = !rst && pend_q.vld && (pend_q.port == PORT_D);
  assign i_err    = i_rvalid && pend_q.err;
  assign d_err    = d_rvalid && pend_q.err;
  assign i_rdata  = (i_rvalid && !pend_q.err) ? mem_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && !pend_q.err) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with mips_sram_1p attached.
// Latency: one vector per clock; responses expected one cycle after grant.
// Backpressure: vectors hold requests until the expected grant.
module tb_mips_mem_arbiter;
  import mips_pkg::*;

  localparam int AW = 10;

  logic        clk1 = 1'b0;
  logic        rst, halt;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter #(.MEM_DEPTH(1024), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .halt(halt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mips_sram_1p #(.DEPTH(1024), .WIDTH(32)) u_mem (
    .clk_i(clk1), .en_i(mem_en), .we_i(mem_we), .addr_i(mem_addr),
    .wdata_i(mem_wdata), .rdata_o(mem_rdata)
  );

  typedef struct {
    logic        rst, halt, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        e_ig, e_dg, e_en, e_we;
  } vec_t;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] data;
  } resp_t;

  int          total = 0;
  int          bad   = 0;
  resp_t       resp_q[$];
  logic [31:0] mdl [1024];
  logic [AW-1:0] last_addr;
  logic [31:0] last_wdata;
  bit          addr_known = 0;
  bit          wdata_known = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(input int r, input int h, input int ir, input logic [31:0] ia,
                              input int dr, input int dw, input logic [31:0] da,
                              input logic [31:0] dd, input int eig, input int edg,
                              input int een, input int ewe);
    vec_t v;
    v.rst = (r != 0); v.halt = (h != 0); v.i_req = (ir != 0); v.i_addr = ia;
    v.d_req = (dr != 0); v.d_we = (dw != 0); v.d_addr = da; v.d_wdata = dd;
    v.e_ig = (eig != 0); v.e_dg = (edg != 0); v.e_en = (een != 0); v.e_we = (ewe != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one vector, check grants/strobes and any due response, then advance a clock.
  task automatic step(input vec_t v, input string nm);
    resp_t         e;
    logic [31:0]   a32;
    logic [AW-1:0] ga;
    logic          oor, wr;
    rst = v.rst; halt = v.halt; i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #3;
    chk({nm, " i_gnt"},  32'(i_gnt),  32'(v.e_ig));
    chk({nm, " d_gnt"},  32'(d_gnt),  32'(v.e_dg));
    chk({nm, " mem_en"}, 32'(mem_en), 32'(v.e_en));
    chk({nm, " mem_we"}, 32'(mem_we), 32'(v.e_we));
    ga = v.e_dg ? v.d_addr[AW-1:0] : v.i_addr[AW-1:0];
    if (v.e_en) begin
      chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ga));
      if (v.e_dg) chk({nm, " mem_wdata"}, mem_wdata, v.d_wdata);
    end
    if (!v.rst && !v.i_req && !v.d_req) begin
      if (addr_known)  chk({nm, " mem_addr hold"}, 32'(mem_addr), 32'(last_addr));
      if (wdata_known) chk({nm, " mem_wdata hold"}, mem_wdata, last_wdata);
    end
    if (v.rst) begin
      chk({nm, " rst i_rvalid"}, 32'(i_rvalid), 32'd0);
      chk({nm, " rst d_rvalid"}, 32'(d_rvalid), 32'd0);
      chk({nm, " rst errs"}, {30'd0, i_err, d_err}, 32'd0);
      chk({nm, " rst i_rdata"}, i_rdata, 32'd0);
      chk({nm, " rst d_rdata"}, d_rdata, 32'd0);
      resp_q.delete();
    end else if (resp_q.size() != 0) begin
      e = resp_q.pop_front();
      chk({nm, " i_rvalid"}, 32'(i_rvalid), 32'(!e.is_d));
      chk({nm, " d_rvalid"}, 32'(d_rvalid), 32'(e.is_d));
      if (e.is_d) begin
        chk({nm, " d_err"}, 32'(d_err), 32'(e.err));
        chk({nm, " d_rdata"}, d_rdata, e.data);
      end else begin
        chk({nm, " i_err"}, 32'(i_err), 32'(e.err));
        chk({nm, " i_rdata"}, i_rdata, e.data);
      end
    end else begin
      chk({nm, " idle i_rvalid"}, 32'(i_rvalid), 32'd0);
      chk({nm, " idle d_rvalid"}, 32'(d_rvalid), 32'd0);
    end
    if (!v.rst && (v.e_ig || v.e_dg)) begin
      a32 = v.e_dg ? v.d_addr : v.i_addr;
      wr  = v.e_dg && v.d_we;
      oor = (a32 >> AW) != 32'd0;
      if (oor || !wr) begin
        e.is_d = v.e_dg;
        e.err  = oor;
        e.data = oor ? 32'd0 : mdl[a32[AW-1:0]];
        resp_q.push_back(e);
      end else begin
        mdl[a32[AW-1:0]] = v.d_wdata;
      end
    end
    if (v.rst) begin
      addr_known = 0;
      wdata_known = 0;
    end else if (v.e_en) begin
      last_addr = ga;
      addr_known = 1;
      if (v.e_dg) begin
        last_wdata = v.d_wdata;
        wdata_known = 1;
      end
    end
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // rst halt | i_req i_addr | d_req d_we d_addr d_wdata | i_gnt d_gnt mem_en mem_we
    tbl.push_back(mk(1,0, 1,5,           1,0,3,0,                  0,0,0,0));
    tbl.push_back(mk(1,0, 0,0,           0,0,0,0,                  0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,1,5,32'hDEAD,           0,1,1,1));
    tbl.push_back(mk(0,0, 0,0,           1,1,9,32'h5555AAAA,       0,1,1,1));
    tbl.push_back(mk(0,0, 0,0,           1,1,3,32'h0BADF00D,       0,1,1,1));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));
    tbl.push_back(mk(0,0, 1,5,           0,0,0,0,                  1,0,1,0));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,1,7,32'h1234,           0,1,1,1));
    tbl.push_back(mk(0,0, 0,0,           1,0,7,0,                  0,1,1,0));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,0,32'h400,0,            0,1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,1,32'h800,32'hFFFF,     0,1,0,0));
    tbl.push_back(mk(0,0, 1,32'hFFFF0000, 0,0,0,0,                 1,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0));
    tbl.push_back(mk(0,0, 1,9,           1,0,3,0,                  1,0,1,0));
    tbl.push_back(mk(0,0, 1,9,           1,0,3,0,                  0,1,1,0));
    tbl.push_back(mk(0,0, 1,9,           1,0,3,0,                  0,1,1,0));
    tbl.push_back(mk(0,0, 0,0,           1,0,3,0,                  0,1,1,0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0));
    tbl.push_back(mk(0,0, 1,9,           1,0,3,0,                  1,0,1,0));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,1,32'h3FF,32'hCAFE,     0,1,1,1));
    tbl.push_back(mk(0,0, 1,32'h3FF,     0,0,0,0,                  1,0,1,0));
    tbl.push_back(mk(0,0, 0,0,           0,0,0,0,                  0,0,0,0));

    @(posedge clk1);
    #1;
    for (int k = 0; k < tbl.size(); k++) step(tbl[k], $sformatf("vec%0d", k));

    // Halt right after a fetch grant: response still arrives, grants stop,
    // and the starvation count is frozen (two denials before, two after).
    step(mk(0,0, 1,5, 0,0,0,0, 1,0,1,0), "halt_ig");
    step(mk(0,1, 1,5, 1,0,3,0, 0,0,0,0), "halt_c1");
    step(mk(0,1, 1,5, 1,0,3,0, 0,0,0,0), "halt_c2");
    step(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0), "halt_s1");
    step(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0), "halt_s2");
    step(mk(0,1, 1,9, 1,0,3,0, 0,0,0,0), "halt_s3");
    step(mk(0,1, 1,9, 1,0,3,0, 0,0,0,0), "halt_s4");
    step(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0), "halt_s5");
    step(mk(0,0, 1,9, 1,0,3,0, 0,1,1,0), "halt_s6");
    step(mk(0,0, 1,9, 1,0,3,0, 1,0,1,0), "halt_s7");
    step(mk(0,0, 0,0, 0,0,0,0, 0,0,0,0), "halt_end");

    // Reset in the cycle after a data read: the response is dropped and
    // the first cycle out of reset grants normally.
    step(mk(0,0, 0,0, 1,0,5,0, 0,1,1,0), "rst_dg");
    step(mk(1,0, 1,5, 1,0,3,0, 0,0,0,0), "rst_on");
    step(mk(0,0, 0,0, 1,0,3,0, 0,1,1,0), "rst_off");
    step(mk(0,0, 0,0, 0,0,0,0, 0,0,0,0), "rst_resp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
